// File: rtl/nios2_vjtag_pkg.sv
// nios2_vjtag_pkg: shared FSM states and widths for the virtual-JTAG host driver
package nios2_vjtag_pkg;
  localparam int VJI_SR_WIDTH = 38;
  localparam int VJI_IR_WIDTH = 2;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, DONE} state_t;
endpackage

// File: rtl/nios2_vjtag_tck_gen.sv
// nios2_vjtag_tck_gen: divided tck with rise and period-end pulses, parked low while disabled
module nios2_vjtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic period_end,
  output logic rise
);
  localparam int PW = $clog2(2 * TCK_DIV);
  logic [PW-1:0] phase;
  assign rise = en && phase == PW'(TCK_DIV - 1);
  assign period_end = en && phase == PW'(2 * TCK_DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      phase <= '0;
      tck <= 1'b0;
    end else begin
      phase <= (!en || period_end) ? '0 : phase + PW'(1);
      tck <= en && (rise || (tck && !period_end));
    end
endmodule

// File: rtl/nios2_vjtag_host_driver.sv
// nios2_vjtag_host_driver: runs one IR-update / DR-capture-shift-update / RTI transaction per command
module nios2_vjtag_host_driver
  import nios2_vjtag_pkg::*;
#(
  parameter int SR_WIDTH = VJI_SR_WIDTH,
  parameter int IR_WIDTH = VJI_IR_WIDTH,
  parameter int TCK_DIV = 2,
  parameter int RTI_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int BW = $clog2(SR_WIDTH + 1);
  localparam int RW = $clog2(RTI_PERIODS + 1);
  state_t state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] rti_cnt;
  logic [SR_WIDTH-1:0] sr;
  logic en, period_end, rise, accept, last_bit, last_rti;
  assign en = state != IDLE && state != DONE;
  assign accept = cmd_valid && cmd_ready;
  assign last_bit = bit_cnt == BW'(SR_WIDTH - 1);
  assign last_rti = rti_cnt == RW'(RTI_PERIODS - 1);
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_data = sr;
  assign vji_uir = state == UIR;
  assign vji_cdr = state == CDR;
  assign vji_sdr = state == SDR;
  assign vji_udr = state == UDR;
  assign vji_rti = state == RTI;
  nios2_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .tck(vji_tck),
    .period_end(period_end),
    .rise(rise)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? UIR : IDLE;
      UIR: state_nx = period_end ? CDR : UIR;
      CDR: state_nx = period_end ? SDR : CDR;
      SDR: state_nx = (period_end && last_bit) ? UDR : SDR;
      UDR: state_nx = period_end ? RTI : UDR;
      RTI: state_nx = (period_end && last_rti) ? DONE : RTI;
      DONE: state_nx = rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // sr shifts at the tck rise, so by the period end sr[0] already holds the next bit to drive
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      sr <= '0;
      vji_tdi <= 1'b0;
      vji_ir_in <= '0;
      bit_cnt <= '0;
      rti_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sr <= cmd_data;
        vji_ir_in <= cmd_ir;
      end else if (rise && state == SDR)
        sr <= {vji_tdo, sr[SR_WIDTH-1:1]};
      if (period_end) vji_tdi <= state_nx == SDR && sr[0];
      if (period_end && state == SDR) bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      if (period_end && state == RTI) rti_cnt <= last_rti ? '0 : rti_cnt + RW'(1);
    end
endmodule

// File: tb/tb_nios2_vjtag_host_driver.sv
// tb_nios2_vjtag_host_driver: cycle-level reference model plus a TAP shift-register model behind tdo
module tb_nios2_vjtag_host_driver;
  localparam int W = 38, IRW = 2, D = 2, R = 2;
  localparam int TOTAL = (3 + W + R) * 2 * D;
  logic clk = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [IRW-1:0] cmd_ir = '0, vji_ir_in;
  logic [W-1:0] cmd_data = '0, rsp_data;
  logic vji_tck, vji_tdi, vji_tdo, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic f_rst_n = 0, f_cmd_valid = 0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 0;
  logic [IRW-1:0] f_cmd_ir = '0, f_ir;
  logic [W-1:0] f_cmd_data = '0, f_rsp_data;
  logic f_tck, f_tdi, f_tdo, f_uir, f_cdr, f_sdr, f_udr, f_rti;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit f_done = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios2_vjtag_host_driver dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );
  nios2_vjtag_host_driver #(.TCK_DIV(1), .RTI_PERIODS(1)) dut_fast (
    .clk(clk), .reset_n(f_rst_n), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_data(f_rsp_data), .vji_tck(f_tck), .vji_tdi(f_tdi), .vji_tdo(f_tdo),
    .vji_ir_in(f_ir), .vji_uir(f_uir), .vji_cdr(f_cdr), .vji_sdr(f_sdr),
    .vji_udr(f_udr), .vji_rti(f_rti)
  );

  // TAP data registers: tdo is the LSB, tdi enters the MSB on each shifting tck rise
  logic [W-1:0] tap = 38'h15_0F0F_F0F0, f_tap = 38'h15_0F0F_F0F0;
  assign vji_tdo = tap[0];
  assign f_tdo = f_tap[0];
  always @(posedge vji_tck) if (vji_sdr) tap <= {vji_tdi, tap[W-1:1]};
  always @(posedge f_tck) if (f_sdr) f_tap <= {f_tdi, f_tap[W-1:1]};

  int ru = 0, rc = 0, rs = 0, rd = 0, rr = 0;
  always @(posedge vji_tck) begin
    ru <= ru + int'(vji_uir);
    rc <= rc + int'(vji_cdr);
    rs <= rs + int'(vji_sdr);
    rd <= rd + int'(vji_udr);
    rr <= rr + int'(vji_rti);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction-level model: m_t is the clk cycle index since acceptance
  bit m_idle = 1, m_done = 0;
  int m_t = 0;
  logic [W-1:0] m_data = '0, m_rsp = '0;
  logic [IRW-1:0] m_ir = '0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_idle <= 1;
      m_done <= 0;
      m_t <= 0;
      m_ir <= '0;
    end else if (m_idle) begin
      if (cmd_valid) begin
        m_idle <= 0;
        m_t <= 0;
        m_data <= cmd_data;
        m_ir <= cmd_ir;
        m_rsp <= tap;
      end
    end else if (!m_done) begin
      m_t <= m_t + 1;
      if (m_t + 1 == TOTAL) m_done <= 1;
    end else if (rsp_ready) begin
      m_idle <= 1;
      m_done <= 0;
    end

  int k_c, ph_c;
  always @(negedge clk) begin
    k_c = m_t / (2 * D);
    ph_c = m_t % (2 * D);
    chk("cmd_ready", cmd_ready, m_idle);
    chk("rsp_valid", rsp_valid, m_done);
    chk("ir_in", vji_ir_in, m_ir);
    chk("strobe_excl", $countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) <= 1, 1);
    if (m_done) chk("rsp_data", rsp_data, m_rsp);
    if (m_idle || m_done) chk("idle_tck_strobes", {vji_tck, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    else begin
      chk("tck", vji_tck, ph_c >= D);
      chk("strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti},
          {k_c == 0, k_c == 1, k_c >= 2 && k_c < 2 + W, k_c == 2 + W, k_c > 2 + W});
      if (k_c >= 2 && k_c < 2 + W) chk("tdi", vji_tdi, m_data[k_c-2]);
    end
  end

  task automatic send(input logic [IRW-1:0] ir, input logic [W-1:0] d, output int acc);
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1;
    for (int i = 0; i < 1000 && !cmd_ready; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int acc, input bit noise, output int lat);
    for (int i = 0; i < 2000 && !rsp_valid; i++) begin
      if (noise) begin
        rsp_ready = 1'($urandom_range(0, 1));
        cmd_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    rsp_ready = 0;
    cmd_valid = 0;
    if (!rsp_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid still 0");
    end
    lat = cyc - acc;
  endtask

  task automatic take_rsp();
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin : main
    int acc, lat, seen, u0, c0, s0, d0, r0;
    logic [W-1:0] d, held;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tck", vji_tck, 0);
    chk("rst_ir", vji_ir_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    u0 = ru; c0 = rc; s0 = rs; d0 = rd; r0 = rr;
    send(2'b01, 38'h2A_5555_AAAA, acc);
    wait_rsp(acc, 0, lat);
    chk("latency", lat, 172);
    chk("basic_rsp", rsp_data, 38'h15_0F0F_F0F0);
    chk("basic_tap", tap, 38'h2A_5555_AAAA);
    chk("basic_ir", vji_ir_in, 2'b01);
    chk("rises_uir", ru - u0, 1);
    chk("rises_cdr", rc - c0, 1);
    chk("rises_sdr", rs - s0, 38);
    chk("rises_udr", rd - d0, 1);
    chk("rises_rti", rr - r0, 2);
    held = rsp_data;
    cmd_ir = 2'b10;
    cmd_data = 38'h01_2345_6789;
    cmd_valid = 1;
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_data", rsp_data, held);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_tck", vji_tck, 0);
    take_rsp();
    chk("bp_ready_back", cmd_ready, 1);
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 0;
    chk("bp_accepted", cmd_ready, 0);
    chk("bp_ir", vji_ir_in, 2'b10);
    wait_rsp(acc, 0, lat);
    chk("bp_latency", lat, 172);
    chk("bp_rsp", rsp_data, 38'h2A_5555_AAAA);
    take_rsp();
    send(2'b11, 38'h0A_AAAA_5555, acc);
    repeat (89) @(posedge clk);
    #3;
    chk("pre_reset_sdr", vji_sdr, 1);
    reset_n = 0;
    #1;
    chk("mid_rst_tck", vji_tck, 0);
    chk("mid_rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_ir", vji_ir_in, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    seen = 0;
    repeat (200) begin @(posedge clk); #1; seen += int'(rsp_valid); end
    chk("no_rsp_after_reset", seen, 0);
    send(2'b01, 38'h3F_FFFF_FFFF, acc);
    wait_rsp(acc, 0, lat);
    chk("post_rst_latency", lat, 172);
    chk("post_rst_tap", tap, 38'h3F_FFFF_FFFF);
    take_rsp();
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d = W'({$urandom(), $urandom()});
      send(IRW'($urandom_range(0, 3)), d, acc);
      wait_rsp(acc, 1, lat);
      chk("rnd_latency", lat, TOTAL);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      take_rsp();
      chk("rnd_tap", tap, d);
    end
    for (int i = 0; i < 2000 && !f_done; i++) @(posedge clk);
    if (!f_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL fast_timeout: fast-build sequence did not finish");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : fast
    int facc, flat;
    logic fprev;
    repeat (3) @(posedge clk);
    #1 f_rst_n = 1;
    f_cmd_ir = 2'b01;
    f_cmd_data = 38'h2A_5555_AAAA;
    f_cmd_valid = 1;
    @(posedge clk); #1;
    facc = cyc;
    f_cmd_valid = 0;
    chk("f_accepted", f_cmd_ready, 0);
    fprev = f_tck;
    chk("f_tck_start", f_tck, 0);
    for (int i = 0; i < 300 && !f_rsp_valid; i++) begin
      @(posedge clk); #1;
      chk("f_tck_toggle", f_tck, !fprev);
      fprev = f_tck;
    end
    flat = cyc - facc;
    chk("f_latency", flat, 84);
    chk("f_rsp_valid", f_rsp_valid, 1);
    chk("f_rsp", f_rsp_data, 38'h15_0F0F_F0F0);
    chk("f_tap", f_tap, 38'h2A_5555_AAAA);
    chk("f_ir", f_ir, 2'b01);
    f_rsp_ready = 1;
    @(posedge clk); #1;
    f_rsp_ready = 0;
    chk("f_ready_back", f_cmd_ready, 1);
    f_done = 1;
  end
endmodule
